hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage core. It drives the hold and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC write enable. It resolves three conditions:
- load-use data hazards
- taken-branch/jump flushes
- multi-cycle data-memory waits, with a timeout watchdog

It also keeps saturating stall and flush counters for performance debug.

---
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes and
// data-memory wait freezes with a timeout watchdog, plus saturating perf counters.
module hazard_ctrl #(
   parameter int unsigned REG_W   = 5,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [REG_W-1:0] rs1_ID,
   input  logic [REG_W-1:0] rs2_ID,
   input  logic             use_rs1_ID,
   input  logic             use_rs2_ID,
   input  logic [REG_W-1:0] rd_EX,
   input  logic             MemRead_EX,
   input  logic             branch_taken_EX,
   input  logic             dmem_req_MEM,
   input  logic             dmem_ready,
   output logic             PC_Write,
   output logic             IF_ID_Hold,
   output logic             IF_ID_Clear,
   output logic             ID_EX_Hold,
   output logic             ID_EX_Clear,
   output logic             EX_MEM_Hold,
   output logic             MEM_WB_Clear,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned     WCW     = $clog2(TIMEOUT + 1);
   localparam logic [WCW-1:0]  WC_LAST = WCW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_WAIT  = 2'd1,
      S_ERROR = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WCW-1:0]   r_wait_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic w_mem_stall;
   logic w_load_use;
   logic w_error;
   logic w_freeze;
   logic w_flush;
   logic w_lu_stall;

   assign w_mem_stall = dmem_req_MEM & ~dmem_ready;
   assign w_load_use  = MemRead_EX & (rd_EX != '0) &
                        ((use_rs1_ID & (rd_EX == rs1_ID)) |
                         (use_rs2_ID & (rd_EX == rs2_ID)));

   // Priority chain: error/freeze mask flush, flush masks load-use.
   assign w_error    = (r_state == S_ERROR);
   assign w_freeze   = w_error | w_mem_stall;
   assign w_flush    = ~w_freeze & branch_taken_EX;
   assign w_lu_stall = ~w_freeze & ~branch_taken_EX & w_load_use;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN: begin
            if (w_mem_stall) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (!w_mem_stall)               w_state_nxt = S_RUN;
            else if (r_wait_cnt == WC_LAST) w_state_nxt = S_ERROR;
         end
         S_ERROR: w_state_nxt = S_ERROR;
         default: w_state_nxt = S_RUN;
      endcase
   end

   always_comb begin
      PC_Write     = ~(w_freeze | w_lu_stall);
      IF_ID_Hold   = w_freeze | w_lu_stall;
      IF_ID_Clear  = w_flush;
      ID_EX_Hold   = w_freeze;
      ID_EX_Clear  = w_flush | w_lu_stall;
      EX_MEM_Hold  = w_freeze;
      MEM_WB_Clear = w_freeze;
      mem_error    = w_error;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_wait_cnt <= '0;
      end else begin
         case (r_state)
            S_RUN:   r_wait_cnt <= w_mem_stall ? WCW'(1) : '0;
            S_WAIT: begin
               if (!w_mem_stall)              r_wait_cnt <= '0;
               else if (r_wait_cnt != WC_LAST) r_wait_cnt <= r_wait_cnt + WCW'(1);
            end
            default: r_wait_cnt <= r_wait_cnt;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if ((w_freeze | w_lu_stall) && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: one instance with a short
// timeout and one with 2-bit counters for saturation.
module tb_hazard_ctrl;

   localparam int unsigned REG_W = 5;

   // {PC_Write, IF_ID_Hold, IF_ID_Clear, ID_EX_Hold, ID_EX_Clear, EX_MEM_Hold, MEM_WB_Clear, mem_error}
   localparam logic [7:0] C_NORM  = 8'b1000_0000;
   localparam logic [7:0] C_FRZ   = 8'b0101_0110;
   localparam logic [7:0] C_FLUSH = 8'b1010_1000;
   localparam logic [7:0] C_LU    = 8'b0100_1000;
   localparam logic [7:0] C_ERR   = 8'b0101_0111;

   logic             CLK = 1'b0;
   logic             RESET_N = 1'b0;
   logic [REG_W-1:0] rs1_ID, rs2_ID, rd_EX;
   logic             use_rs1_ID, use_rs2_ID, MemRead_EX, branch_taken_EX;
   logic             dmem_req_MEM, dmem_ready;

   logic        a_pc, a_ifh, a_ifc, a_idh, a_idc, a_exh, a_mwc, a_err;
   logic [15:0] a_stall, a_flush;
   logic        b_pc, b_ifh, b_ifc, b_idh, b_idc, b_exh, b_mwc, b_err;
   logic [1:0]  b_stall, b_flush;

   logic [7:0]  w_ctrl;
   assign w_ctrl = {a_pc, a_ifh, a_ifc, a_idh, a_idc, a_exh, a_mwc, a_err};

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   hazard_ctrl #(.REG_W(REG_W), .TIMEOUT(4), .CNT_W(16)) u_dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
      .rd_EX(rd_EX), .MemRead_EX(MemRead_EX), .branch_taken_EX(branch_taken_EX),
      .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
      .PC_Write(a_pc), .IF_ID_Hold(a_ifh), .IF_ID_Clear(a_ifc), .ID_EX_Hold(a_idh),
      .ID_EX_Clear(a_idc), .EX_MEM_Hold(a_exh), .MEM_WB_Clear(a_mwc), .mem_error(a_err),
      .stall_cnt(a_stall), .flush_cnt(a_flush)
   );

   hazard_ctrl #(.REG_W(REG_W), .TIMEOUT(64), .CNT_W(2)) u_sat (
      .CLK(CLK), .RESET_N(RESET_N),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
      .rd_EX(rd_EX), .MemRead_EX(MemRead_EX), .branch_taken_EX(branch_taken_EX),
      .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
      .PC_Write(b_pc), .IF_ID_Hold(b_ifh), .IF_ID_Clear(b_ifc), .ID_EX_Hold(b_idh),
      .ID_EX_Clear(b_idc), .EX_MEM_Hold(b_exh), .MEM_WB_Clear(b_mwc), .mem_error(b_err),
      .stall_cnt(b_stall), .flush_cnt(b_flush)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [REG_W-1:0] rs1, input logic u1,
                        input logic [REG_W-1:0] rs2, input logic u2,
                        input logic [REG_W-1:0] rd, input logic mr, input logic br,
                        input logic req, input logic rdy);
      rs1_ID = rs1; use_rs1_ID = u1; rs2_ID = rs2; use_rs2_ID = u2;
      rd_EX = rd; MemRead_EX = mr; branch_taken_EX = br;
      dmem_req_MEM = req; dmem_ready = rdy;
      #1;
   endtask

   task automatic quiet();
      drive('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_reset(input string tag);
      quiet();
      RESET_N = 1'b0;
      #1;
      chk({tag, "_ctrl"}, 32'(w_ctrl), 32'(C_NORM));
      chk({tag, "_stall"}, 32'(a_stall), 32'd0);
      chk({tag, "_flush"}, 32'(a_flush), 32'd0);
      RESET_N = 1'b1;
      #1;
   endtask

   initial begin
      quiet();
      RESET_N = 1'b0;
      #12;
      chk("rst_ctrl", 32'(w_ctrl), 32'(C_NORM));
      chk("rst_stall", 32'(a_stall), 32'd0);
      chk("rst_flush", 32'(a_flush), 32'd0);
      chk("rst_sat_stall", 32'(b_stall), 32'd0);
      tick();
      RESET_N = 1'b1;

      // load x5 in EX, ID reads rs1=x5: one bubble
      drive(5'd5, 1'b1, 5'd9, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lu_rs1_ctrl", 32'(w_ctrl), 32'(C_LU));
      tick();
      drive(5'd5, 1'b1, 5'd9, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu_after_ctrl", 32'(w_ctrl), 32'(C_NORM));
      chk("lu_stall", 32'(a_stall), 32'd1);
      tick();

      // x0 never hazards; unused rs2 never hazards
      drive(5'd0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("x0_ctrl", 32'(w_ctrl), 32'(C_NORM));
      tick();
      drive(5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rs2_unused_ctrl", 32'(w_ctrl), 32'(C_NORM));
      tick();
      drive(5'd3, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lu_rs2_ctrl", 32'(w_ctrl), 32'(C_LU));
      tick();
      quiet();
      chk("lu_rs2_stall", 32'(a_stall), 32'd2);

      // branch wins over load-use
      pulse_reset("rst2");
      drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("br_lu_ctrl", 32'(w_ctrl), 32'(C_FLUSH));
      tick();
      quiet();
      chk("br_lu_flush", 32'(a_flush), 32'd1);
      chk("br_lu_stall", 32'(a_stall), 32'd0);

      // memory wait with pending branch: 3 freezes, then flush
      pulse_reset("rst3");
      for (int i = 0; i < 3; i++) begin
         drive('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
         chk($sformatf("frz_br_%0d", i), 32'(w_ctrl), 32'(C_FRZ));
         tick();
      end
      drive('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("frz_release_ctrl", 32'(w_ctrl), 32'(C_FLUSH));
      tick();
      quiet();
      chk("frz_after_ctrl", 32'(w_ctrl), 32'(C_NORM));
      chk("frz_stall", 32'(a_stall), 32'd3);
      chk("frz_flush", 32'(a_flush), 32'd1);

      // wait aborted by dropped request restarts the timeout window
      pulse_reset("rst4");
      for (int i = 0; i < 2; i++) begin
         drive('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
         chk($sformatf("wait_a_%0d", i), 32'(w_ctrl), 32'(C_FRZ));
         tick();
      end
      quiet();
      chk("wait_drop_ctrl", 32'(w_ctrl), 32'(C_NORM));
      tick();
      for (int i = 0; i < 4; i++) begin
         drive('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
         chk($sformatf("wait_b_%0d", i), 32'(w_ctrl), 32'(C_FRZ));
         tick();
      end
      chk("err_ctrl", 32'(w_ctrl), 32'(C_ERR));
      chk("err_stall", 32'(a_stall), 32'd6);
      drive('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("err_req_drop", 32'(w_ctrl), 32'(C_ERR));
      drive(5'd5, 1'b1, '0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("err_br_lu", 32'(w_ctrl), 32'(C_ERR));
      tick();
      tick();
      chk("err_sticky", 32'(w_ctrl), 32'(C_ERR));
      chk("err_stall2", 32'(a_stall), 32'd8);
      chk("err_flush", 32'(a_flush), 32'd0);
      pulse_reset("rst_err");
      chk("rst_err_memerr", 32'(a_err), 32'd0);

      // saturation with 2-bit counters
      for (int i = 0; i < 5; i++) begin
         drive(5'd12, 1'b1, '0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
         chk($sformatf("sat_ctrl_%0d", i), 32'({b_pc, b_ifh, b_ifc, b_idh, b_idc, b_exh, b_mwc, b_err}), 32'(C_LU));
         tick();
         chk($sformatf("sat_stall_%0d", i), 32'(b_stall), (i < 3) ? 32'(i + 1) : 32'd3);
      end
      quiet();
      chk("sat_wide_stall", 32'(a_stall), 32'd5);
      chk("sat_flush", 32'(b_flush), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
